src_datapath_p: RTL
===================

# src_datapath_p

Parametrised bus-based datapath for the Mini SRC processor and the successor to the fixed 32-bit, 16-register datapath. It keeps the single shared bus and the R0/Y/Z/HI/LO/PC/IR/MAR/MDR organisation, with these changes:
- Register count and word width are parameters.
- Bus sources are selected by encoded fields instead of one-hot lines.
- MUL/DIV run as a multi-cycle sequential unit with busy/done.
- Memory is reached through a req/ack handshake that tolerates wait states.

The block sits between the control unit (which drives the select/enable fields) and external RAM/IO.

## Interface
Parameters:
- WIDTH, 32, data word and bus width (≥8, even)
- NREG, 16, general registers (power of 2, ≥4)
- ADDR_W, 9, memory address width (MAR holds the low ADDR_W bits of the bus)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- clr  in  1  asynchronous, active-high reset
- reg_out  in  1  drive the bus from the register at reg_rsel
- reg_rsel  in  $clog2(NREG)  register read index
- ba_out  in  1  with reg_rsel=0, R0 reads as zero (base-address mode)
- src_sel  in  3  non-register bus source: HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN; used when reg_out=0
- reg_en  in  1  write bus into register reg_wsel
- reg_wsel  in  $clog2(NREG)  register write index
- y_en, z_en, hi_en, lo_en, ir_en, mar_en, outp_en  in  1 each  load from the bus; z_en loads Z from the ALU result
- pc_en  in  1  load PC from the bus
- pc_inc  in  1  PC += 1
- mdr_en  in  1  load MDR from the bus
- alu_op  in  4  operation code (package enum)
- alu_start  in  1  launch a MUL/DIV
- con_in  in  1  latch the branch condition
- mem_start  in  1  begin a memory access
- mem_we  in  1  1 = write, 0 = read; sampled with mem_start
- mem_req  out  1  request to RAM
- mem_wr  out  1  write strobe qualifier
- mem_ack  in  1  RAM completion
- mem_addr  out  ADDR_W  MAR contents
- mem_wdata  out  WIDTH  MDR contents
- mem_rdata  in  WIDTH  RAM read data
- in_port  in  WIDTH  input port data
- out_port  out  WIDTH  output port register
- bus  out  WIDTH  current bus value, for observation
- ir  out  WIDTH  IR contents
- con  out  1  condition flip-flop
- md_busy  out  1  MUL/DIV in progress
- md_done  out  1  one-cycle pulse when MUL/DIV completes
- mem_busy  out  1  memory access in progress
- mem_done  out  1  one-cycle pulse when the access completes

## Operation
- Bus is combinational.
  - reg_out=1: bus = reg[reg_rsel], or 0 when reg_rsel=0 and ba_out=1.
  - reg_out=0: bus = the src_sel source.
  - CSIGN = IR[18:0] sign-extended to WIDTH.
- Single-cycle ALU ops (ADD, SUB, AND, OR, SHL, SHR, SHRA, ROL, ROR, NEG, NOT) compute from A=Y and B=bus.
  - Shift/rotate amount is bus[$clog2(WIDTH)-1:0].
  - z_en writes {ZHI,ZLO} = {0, result}.
- MUL/DIV (signed), operands A=Y and B=bus, both captured at alu_start.
  - MUL: shift-add. Z = 2·WIDTH-bit product.
  - DIV: restoring division on magnitudes. ZLO = quotient, truncated toward zero. ZHI = remainder, which takes the sign of the dividend.
  - Divide by zero: ZLO = all ones, ZHI = dividend.
- MUL/DIV FSM states: IDLE → RUN (WIDTH cycles) → FIX (one cycle, sign correction, Z written) → IDLE.
- Memory FSM states: IDLE → REQ (mem_req=1, mem_wr=mem_we held) → IDLE on mem_ack.
  - On a read, MDR ← mem_rdata in the ack cycle.
- CON: on con_in, con ← evaluated from IR[20:19] against the bus.
  - 00 always, 01 never, 10 bus==0, 11 bus≠0.

## Timing
- Reset: all registers, PC, IR, Y, Z, HI, LO, MAR, MDR, out_port and con are 0. Both FSMs go to IDLE. All outputs are 0.
- Register loads take effect on the next edge, so a value written in cycle n is readable on the bus in cycle n+1.
- MUL/DIV latency:
  - alu_start at edge n sets md_busy from n+1.
  - Z is written and md_done pulses at edge n+WIDTH+1; md_busy drops at the same edge.
- Ignored or overridden inputs:
  - alu_start while md_busy is ignored.
  - z_en while md_busy is ignored.
  - Single-cycle op with z_en in the same cycle as alu_start: alu_start wins.
  - mem_start while mem_busy is ignored.
  - mdr_en during REQ of a read is ignored; mem_ack wins.
- Memory: MAR and MDR are frozen during REQ. mem_done pulses in the cycle after mem_ack is sampled.
- mem_ack in the same cycle as mem_start is not seen; the minimum access is 2 cycles.
- Priority: pc_en beats pc_inc. reg_en to R0 is allowed (R0 is a real register).
- clr mid-operation aborts both FSMs. No done pulse follows.
- MUL/DIV and memory run concurrently and independently.

## Structure
- Package src_dp_pkg holds:
  - alu_op enum
  - src_sel enum
  - FSM state enums for MUL/DIV and memory
  - CSIGN field position constants
- Sub-module seq_muldiv(WIDTH) holds the MUL/DIV FSM, operand/accumulator registers and sign fix-up.
- Register file, bus mux, memory FSM and CON logic stay in the top module.

## Test plan
- Reset/bus read-back, WIDTH=32: after clr, write 0x1234 to R5, read with reg_out → bus=0x1234. R0=7 read with ba_out=1 → bus=0.
- ALU ops: Y=-6, bus=4. ADD → ZLO=0xFFFFFFFE, ZHI=0. SHRA of 0x80000000 by 4 → 0xF8000000.
- MUL: Y=-3, bus=7, alu_start → md_done exactly 33 cycles later, {ZHI,ZLO}=0xFFFFFFFF_FFFFFFEB.
- DIV:
  - Y=-7, bus=2 → ZLO=-3, ZHI=-1.
  - bus=0 → ZLO=0xFFFFFFFF, ZHI=-7.
  - clr at cycle 10 of a DIV → no md_done, all zero.
- Memory: read with mem_ack after 3 wait cycles, mem_rdata=0xCAFE → MDR=0xCAFE, mem_done once. A second mem_start during REQ is ignored.
- CON and parametrisation:
  - IR[20:19]=10 with bus=0 → con=1; with bus=5 → con=0.
  - Rerun scenarios 1–3 with WIDTH=16, NREG=8: MUL latency 17 cycles.

Source files
------------

// File: rtl/src_dp_pkg.sv
// Shared types and field positions for the parametrised Mini SRC datapath.
package src_dp_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_SHRA = 4'd6,
    ALU_ROL  = 4'd7,
    ALU_ROR  = 4'd8,
    ALU_NEG  = 4'd9,
    ALU_NOT  = 4'd10,
    ALU_MUL  = 4'd11,
    ALU_DIV  = 4'd12
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_HI     = 3'd0,
    SRC_LO     = 3'd1,
    SRC_ZHI    = 3'd2,
    SRC_ZLO    = 3'd3,
    SRC_PC     = 3'd4,
    SRC_MDR    = 3'd5,
    SRC_INPORT = 3'd6,
    SRC_CSIGN  = 3'd7
  } src_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_REQ  = 1'b1
  } mem_state_e;

  localparam int CSIGN_MSB  = 18;
  localparam int COND_LSB   = 19;
  localparam int COND_MSB   = 20;
  localparam int IR_FIELD_W = COND_MSB + 1;

endpackage

// File: rtl/src_datapath_p_muldiv.sv
// Sequential signed MUL (shift-add) / DIV (restoring) on operand magnitudes,
// with a final sign fix-up cycle that presents the Z result.
module seq_muldiv
  import src_dp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             fix,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             div_r, neg_a_r, neg_b_r, b_zero_r, done_r;
  logic [WIDTH-1:0] dvd_r, mcand_r, acc_r, mq_r;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, acc_nx_s, mq_nx_s, q_s, r_s;
  logic [WIDTH:0]   sum_s, shl_s, trial_s;
  logic [2*WIDTH-1:0] prod_s;

  // One iteration of shift-add or restoring division, plus final sign fix-up.
  always_comb begin
    a_mag_s = a[WIDTH-1] ? -a : a;
    b_mag_s = b[WIDTH-1] ? -b : b;
    sum_s   = {1'b0, acc_r} + (mq_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    shl_s   = {acc_r, mq_r[WIDTH-1]};
    trial_s = shl_s - {1'b0, mcand_r};
    if (div_r) begin
      if (trial_s[WIDTH]) begin
        acc_nx_s = shl_s[WIDTH-1:0];
        mq_nx_s  = {mq_r[WIDTH-2:0], 1'b0};
      end else begin
        acc_nx_s = trial_s[WIDTH-1:0];
        mq_nx_s  = {mq_r[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nx_s = sum_s[WIDTH:1];
      mq_nx_s  = {sum_s[0], mq_r[WIDTH-1:1]};
    end
    prod_s = (neg_a_r ^ neg_b_r) ? -{acc_r, mq_r} : {acc_r, mq_r};
    q_s    = (neg_a_r ^ neg_b_r) ? -mq_r : mq_r;
    r_s    = neg_a_r ? -acc_r : acc_r;
    if (!div_r) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (b_zero_r) begin
      res_hi = dvd_r;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = r_s;
      res_lo = q_s;
    end
  end

  // Operand capture and IDLE -> RUN (WIDTH steps) -> FIX -> IDLE sequencing.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= MD_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      div_r    <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      b_zero_r <= 1'b0;
      done_r   <= 1'b0;
      dvd_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      mq_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            state_r  <= MD_RUN;
            cnt_r    <= {CNT_W{1'b0}};
            div_r    <= op_div;
            neg_a_r  <= a[WIDTH-1];
            neg_b_r  <= b[WIDTH-1];
            b_zero_r <= (b == {WIDTH{1'b0}});
            dvd_r    <= a;
            mcand_r  <= b_mag_s;
            acc_r    <= {WIDTH{1'b0}};
            mq_r     <= a_mag_s;
          end
        end
        MD_RUN: begin
          acc_r <= acc_nx_s;
          mq_r  <= mq_nx_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= MD_FIX;
          end
        end
        MD_FIX: begin
          state_r <= MD_IDLE;
          done_r  <= 1'b1;
        end
        default: state_r <= MD_IDLE;
      endcase
    end
  end

  assign busy = (state_r != MD_IDLE);
  assign fix  = (state_r == MD_FIX);
  assign done = done_r;

endmodule

// File: rtl/src_datapath_p.sv
// Parametrised single-bus Mini SRC datapath: register file, bus mux, ALU,
// sequential MUL/DIV, req/ack memory interface and branch condition flop.
module src_datapath_p
  import src_dp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREG   = 16,
  parameter int ADDR_W = 9
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    reg_out,
  input  logic [$clog2(NREG)-1:0] reg_rsel,
  input  logic                    ba_out,
  input  logic [2:0]              src_sel,
  input  logic                    reg_en,
  input  logic [$clog2(NREG)-1:0] reg_wsel,
  input  logic                    y_en,
  input  logic                    z_en,
  input  logic                    hi_en,
  input  logic                    lo_en,
  input  logic                    ir_en,
  input  logic                    mar_en,
  input  logic                    outp_en,
  input  logic                    pc_en,
  input  logic                    pc_inc,
  input  logic                    mdr_en,
  input  logic [3:0]              alu_op,
  input  logic                    alu_start,
  input  logic                    con_in,
  input  logic                    mem_start,
  input  logic                    mem_we,
  output logic                    mem_req,
  output logic                    mem_wr,
  input  logic                    mem_ack,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic [WIDTH-1:0]        in_port,
  output logic [WIDTH-1:0]        out_port,
  output logic [WIDTH-1:0]        bus,
  output logic [WIDTH-1:0]        ir,
  output logic                    con,
  output logic                    md_busy,
  output logic                    md_done,
  output logic                    mem_busy,
  output logic                    mem_done
);

  localparam int SEL_W = $clog2(NREG);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CS_W  = (WIDTH > CSIGN_MSB + 1) ? WIDTH : CSIGN_MSB + 1;
  localparam logic [SH_W:0] WIDTH_L = (SH_W + 1)'(WIDTH);

  logic [WIDTH-1:0]  regs_r [NREG];
  logic [WIDTH-1:0]  pc_r, ir_r, y_r, zhi_r, zlo_r, hi_r, lo_r, mdr_r, out_r;
  logic [ADDR_W-1:0] mar_r;
  logic              con_r, mem_wr_r, mem_done_r;
  mem_state_e        mem_state_r;

  logic [WIDTH-1:0]      bus_s, alu_res_s, csign_s, md_hi_s, md_lo_s;
  logic [IR_FIELD_W-1:0] ir_f_s;
  logic [CS_W-1:0]       csign_full_s;
  logic [SH_W-1:0]       shamt_s;
  logic [SH_W:0]         rsh_s;
  logic                  con_nx_s, md_busy_s, md_fix_s, md_start_s, is_md_s;

  // IR fields are read through a fixed-width view so narrow words still elaborate.
  always_comb begin
    ir_f_s       = IR_FIELD_W'(ir_r);
    csign_full_s = CS_W'($signed(ir_f_s[CSIGN_MSB:0]));
    csign_s      = csign_full_s[WIDTH-1:0];
  end

  // Shared bus source selection.
  always_comb begin
    if (reg_out) begin
      if (ba_out && (reg_rsel == {SEL_W{1'b0}})) begin
        bus_s = {WIDTH{1'b0}};
      end else begin
        bus_s = regs_r[reg_rsel];
      end
    end else begin
      case (src_sel_e'(src_sel))
        SRC_HI:     bus_s = hi_r;
        SRC_LO:     bus_s = lo_r;
        SRC_ZHI:    bus_s = zhi_r;
        SRC_ZLO:    bus_s = zlo_r;
        SRC_PC:     bus_s = pc_r;
        SRC_MDR:    bus_s = mdr_r;
        SRC_INPORT: bus_s = in_port;
        SRC_CSIGN:  bus_s = csign_s;
        default:    bus_s = {WIDTH{1'b0}};
      endcase
    end
  end

  // Single-cycle ALU, A = Y and B = bus; rotates combine two opposite shifts.
  always_comb begin
    shamt_s = bus_s[SH_W-1:0];
    rsh_s   = WIDTH_L - {1'b0, shamt_s};
    case (alu_op_e'(alu_op))
      ALU_ADD:  alu_res_s = y_r + bus_s;
      ALU_SUB:  alu_res_s = y_r - bus_s;
      ALU_AND:  alu_res_s = y_r & bus_s;
      ALU_OR:   alu_res_s = y_r | bus_s;
      ALU_SHL:  alu_res_s = y_r << shamt_s;
      ALU_SHR:  alu_res_s = y_r >> shamt_s;
      ALU_SHRA: alu_res_s = $signed(y_r) >>> shamt_s;
      ALU_ROL:  alu_res_s = (y_r << shamt_s) | (y_r >> rsh_s);
      ALU_ROR:  alu_res_s = (y_r >> shamt_s) | (y_r << rsh_s);
      ALU_NEG:  alu_res_s = -bus_s;
      ALU_NOT:  alu_res_s = ~bus_s;
      default:  alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Branch condition from IR[20:19] against the bus.
  always_comb begin
    case (ir_f_s[COND_MSB:COND_LSB])
      2'b00:   con_nx_s = 1'b1;
      2'b01:   con_nx_s = 1'b0;
      2'b10:   con_nx_s = (bus_s == {WIDTH{1'b0}});
      2'b11:   con_nx_s = (bus_s != {WIDTH{1'b0}});
      default: con_nx_s = 1'b0;
    endcase
  end

  assign is_md_s    = (alu_op_e'(alu_op) == ALU_MUL) || (alu_op_e'(alu_op) == ALU_DIV);
  assign md_start_s = alu_start && !md_busy_s && is_md_s;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .clr    (clr),
    .start  (md_start_s),
    .op_div (alu_op_e'(alu_op) == ALU_DIV),
    .a      (y_r),
    .b      (bus_s),
    .busy   (md_busy_s),
    .done   (md_done),
    .fix    (md_fix_s),
    .res_hi (md_hi_s),
    .res_lo (md_lo_s)
  );

  // General register file; R0 is a real register, zeroed only on the bus by ba_out.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
    end else if (reg_en) begin
      regs_r[reg_wsel] <= bus_s;
    end
  end

  // Special registers; a finishing MUL/DIV owns Z, and a launch suppresses z_en.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_r  <= {WIDTH{1'b0}};
      ir_r  <= {WIDTH{1'b0}};
      y_r   <= {WIDTH{1'b0}};
      zhi_r <= {WIDTH{1'b0}};
      zlo_r <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      out_r <= {WIDTH{1'b0}};
      con_r <= 1'b0;
    end else begin
      if (pc_en) pc_r <= bus_s;
      else if (pc_inc) pc_r <= pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
      if (ir_en)   ir_r  <= bus_s;
      if (y_en)    y_r   <= bus_s;
      if (hi_en)   hi_r  <= bus_s;
      if (lo_en)   lo_r  <= bus_s;
      if (outp_en) out_r <= bus_s;
      if (con_in)  con_r <= con_nx_s;
      if (md_fix_s) begin
        zhi_r <= md_hi_s;
        zlo_r <= md_lo_s;
      end else if (z_en && !md_busy_s && !alu_start) begin
        zhi_r <= {WIDTH{1'b0}};
        zlo_r <= alu_res_s;
      end
    end
  end

  // Memory handshake: MAR/MDR frozen while a request is outstanding.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_state_r <= MEM_IDLE;
      mem_wr_r    <= 1'b0;
      mem_done_r  <= 1'b0;
      mar_r       <= {ADDR_W{1'b0}};
      mdr_r       <= {WIDTH{1'b0}};
    end else begin
      mem_done_r <= 1'b0;
      case (mem_state_r)
        MEM_IDLE: begin
          if (mar_en) mar_r <= bus_s[ADDR_W-1:0];
          if (mdr_en) mdr_r <= bus_s;
          if (mem_start) begin
            mem_state_r <= MEM_REQ;
            mem_wr_r    <= mem_we;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            mem_state_r <= MEM_IDLE;
            mem_wr_r    <= 1'b0;
            mem_done_r  <= 1'b1;
            if (!mem_wr_r) mdr_r <= mem_rdata;
          end
        end
        default: mem_state_r <= MEM_IDLE;
      endcase
    end
  end

  assign bus       = bus_s;
  assign ir        = ir_r;
  assign con       = con_r;
  assign out_port  = out_r;
  assign md_busy   = md_busy_s;
  assign mem_req   = (mem_state_r == MEM_REQ);
  assign mem_busy  = (mem_state_r == MEM_REQ);
  assign mem_wr    = mem_wr_r;
  assign mem_done  = mem_done_r;
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;

endmodule
